led_trail_pwm: RTL
==================

LED_TRAIL_PWM -- requirements
Module: led_trail_pwm

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8: width of the PWM counter, brightness levels and duties.
REQ-002 SHALL have parameter DECAY_DIV, default 23438: clk cycles between decay ticks, legal range >= 2.
REQ-003 SHALL have parameter DECAY_STEP, default 8: brightness decrement per decay tick, legal range 1..2^PWM_BITS-1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port led_in, input, 4 bits: per-channel "lit" request from the upstream chaser state machine; any combination of bits is legal.
REQ-007 SHALL have port led_out, output, 4 bits, registered: per-channel PWM drive to the board LEDs.

Function
REQ-008 SHALL register led_in once (led_q) before any use; no combinational path from led_in to led_out.
REQ-009 SHALL keep a free-running counter pwm_cnt (PWM_BITS bits) that increments every cycle and wraps from 2^PWM_BITS-1 to 0.
REQ-010 SHALL keep a prescaler counting 0..DECAY_DIV-1 that wraps to 0, with a one-cycle decay tick asserted when prescaler == DECAY_DIV-1.
REQ-011 SHALL keep a per-channel level lvl[i] (PWM_BITS bits); when led_q[i]=1, lvl[i] is loaded with 2^PWM_BITS-1 on that cycle.
REQ-012 SHALL, when led_q[i]=0 and a decay tick occurs, set lvl[i] to lvl[i]-DECAY_STEP saturated at 0; it never wraps to a high value.
REQ-013 SHALL give the load a higher priority than decay when led_q[i]=1 and a decay tick occur in the same cycle.
REQ-014 SHALL latch a shadow duty[i] from f(lvl[i]) only in the cycle where pwm_cnt == 2^PWM_BITS-1, so duty changes only at PWM period boundaries and produces no glitch pulses.
REQ-015 SHALL set led_out[i] <= (pwm_cnt < duty[i]) each cycle, giving duty 0 = constantly off and duty D = D high cycles per 2^PWM_BITS-cycle period.
REQ-016 SHALL keep the four channels fully independent; several lit channels are each handled per REQ-011..015.
REQ-017 SHALL, after a rising led_in[i], apply the new duty to led_out[i] from the first PWM period that starts after the next wrap following lvl load (led_out is registered, so 1 extra cycle).

Reset
REQ-018 SHALL clear, while rst=1 on a clock edge, led_q, pwm_cnt, prescaler, all lvl[i], all duty[i] and led_out to 0.
REQ-019 SHALL have led_out = 4'b0000 on the first edge with rst=1, including during active PWM and decay.
REQ-020 SHALL have pwm_cnt and prescaler count from 0 on the first cycle after rst is deasserted.
REQ-021 SHALL ignore led_in while rst=1, with no lvl load.

Configuration
REQ-022 SHALL implement gamma correction when macro LED_TRAIL_GAMMA_EN is defined: f(lvl) = (lvl*lvl) >> PWM_BITS, using a 2*PWM_BITS-bit product.
REQ-023 SHALL use the linear mapping f(lvl) = lvl when LED_TRAIL_GAMMA_EN is undefined, with no multiplier synthesized.

Verification (PWM_BITS=4, DECAY_DIV=4, DECAY_STEP=4 unless stated)
REQ-024 SHALL cover reset: rst=1 for 3 cycles with led_in=4'b1111 -> led_out=0 throughout, all lvl=0, and pwm_cnt=0 on the first cycle after release.
REQ-025 SHALL cover a steady lit channel: led_in=4'b0001 held, linear -> once duty latched, led_out[0] high 15 of every 16 cycles, with led_out[3:1]=0.
REQ-026 SHALL cover decay and saturation: release led_in[0] -> lvl[0] goes 15,11,7,3,0 on successive ticks and stays 0; per-period on-counts are 15,11,7,3,0 after each latch.
REQ-027 SHALL cover simultaneous events: led_in[1] registered in the same cycle as a decay tick, with lvl[1]=7 -> lvl[1]=15, not 3.
REQ-028 SHALL cover reset mid-operation: rst pulsed for 1 cycle while duty[2]=11 and led_out[2]=1 -> led_out[2]=0 the next cycle, and no output until re-lit.
REQ-029 SHALL cover gamma: with LED_TRAIL_GAMMA_EN defined, lvl 15 -> duty 14, lvl 7 -> duty 3, lvl 3 -> duty 0.

Source files
------------

// File: rtl/led_trail_pwm.sv
// led_trail_pwm: four-channel LED trail fader. A lit channel jumps to full brightness and then decays; each level is emitted as PWM. Define LED_TRAIL_GAMMA_EN to use a squared brightness curve.
// Latency: led_in -> lvl is 2 cycles; the new duty is used from the next PWM wrap, and led_out adds 1 more cycle.
// Backpressure: none; the block is free-running and samples led_in every cycle.
module led_trail_pwm #(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 23438,
  parameter int DECAY_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] led_in,
  output logic [3:0] led_out
);

  localparam int                  PRE_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
  localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);

  logic [3:0]          led_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    prescaler;
  logic                decay_tick;
  logic                pwm_wrap;
  logic [PWM_BITS-1:0] lvl  [4];
  logic [PWM_BITS-1:0] duty [4];

  // Saturating decrement: the level must never wrap back to a bright value.
  function automatic logic [PWM_BITS-1:0] lvl_dec(input logic [PWM_BITS-1:0] l);
    return (l > STEP) ? (l - STEP) : '0;
  endfunction

  function automatic logic [PWM_BITS-1:0] shape(input logic [PWM_BITS-1:0] l);
`ifdef LED_TRAIL_GAMMA_EN
    logic [2*PWM_BITS-1:0] prod;
    prod = {{PWM_BITS{1'b0}}, l} * {{PWM_BITS{1'b0}}, l};
    return prod[2*PWM_BITS-1:PWM_BITS];
`else
    return l;
`endif
  endfunction

  assign decay_tick = (prescaler == PRE_LAST);
  assign pwm_wrap   = (pwm_cnt == LVL_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      pwm_cnt   <= '0;
      prescaler <= '0;
    end else begin
      led_q     <= led_in;
      pwm_cnt   <= pwm_cnt + 1'b1;
      prescaler <= decay_tick ? '0 : prescaler + 1'b1;
    end
  end

  // Load outranks decay; duty is only resampled at the period boundary so no partial pulses appear.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        lvl[i]  <= '0;
        duty[i] <= '0;
      end else begin
        if (led_q[i]) begin
          lvl[i] <= LVL_MAX;
        end else if (decay_tick) begin
          lvl[i] <= lvl_dec(lvl[i]);
        end
        if (pwm_wrap) begin
          duty[i] <= shape(lvl[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        led_out[i] <= 1'b0;
      end else begin
        led_out[i] <= (pwm_cnt < duty[i]);
      end
    end
  end

endmodule
